// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data bundle for one side of pipe_stage_skid.
// master drives valid/data and samples ready; slave does the reverse.
interface pipe_stage_skid_if #(
   parameter int DW = 64
) ();
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: registered in_ready, two-entry skid, synchronous flush.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_skid #(
   parameter int DW         = 64,
   parameter bit CLEAR_DATA = 1'b1,
   parameter int CW         = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   pipe_stage_skid_if.slave   in_if,
   pipe_stage_skid_if.master  out_if
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,
   output logic [CW-1:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } state_t;

   state_t        state_reg;
   logic          in_ready_reg;
   logic          out_valid_reg;
   logic [DW-1:0] main_reg;
   logic [DW-1:0] skid_reg;

   // Handshake flags are registered alongside the state so neither depends on inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         main_reg      <= '0;
         skid_reg      <= '0;
      end else if (flush) begin
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         if (CLEAR_DATA) begin
            main_reg <= '0;
            skid_reg <= '0;
         end
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_if.valid) begin
                  main_reg      <= in_if.data;
                  state_reg     <= BUSY;
                  out_valid_reg <= 1'b1;
                  in_ready_reg  <= 1'b1;
               end
            end
            BUSY: begin
               if (in_if.valid && out_if.ready) begin
                  main_reg <= in_if.data;
               end else if (in_if.valid) begin
                  // Downstream stalled: park the new beat so in_ready can drop a cycle late.
                  skid_reg     <= in_if.data;
                  state_reg    <= FULL;
                  in_ready_reg <= 1'b0;
               end else if (out_if.ready) begin
                  state_reg     <= EMPTY;
                  out_valid_reg <= 1'b0;
               end
            end
            FULL: begin
               if (out_if.ready) begin
                  main_reg     <= skid_reg;
                  state_reg    <= BUSY;
                  in_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.ready  = in_ready_reg;
   assign out_if.valid = out_valid_reg;
   assign out_if.data  = main_reg;

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CW-1:0] stall_cnt_reg;
   logic [CW-1:0] stall_cnt_next;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (out_valid_reg && !out_if.ready && (stall_cnt_reg != {CW{1'b1}})) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   // Only reset clears the counter; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   logic unused_cw;
   assign unused_cw = (CW > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, corner sequences, scoreboarded random run.
// Stall-counter checks are compiled in when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_skid;

   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   pipe_stage_skid_if #(.DW(DW)) in_bus ();
   pipe_stage_skid_if #(.DW(DW)) out_bus ();

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CW-1:0] stall_cnt;
`endif

   pipe_stage_skid #(
      .DW        (DW),
      .CLEAR_DATA(1'b1),
      .CW        (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .in_if (in_bus),
      .out_if(out_bus)
`ifdef PIPE_STAGE_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          fl;
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          ev;
      logic          er;
      logic [DW-1:0] ed;
   } vec_t;

   vec_t            vecs [21];
   logic [DW-1:0]   sb_q [$];
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic er, input logic [DW-1:0] ed);
      check({tag, ".out_valid"}, 64'(out_bus.valid), 64'(ev));
      check({tag, ".in_ready"},  64'(in_bus.ready),  64'(er));
      check({tag, ".out_data"},  64'(out_bus.data),  64'(ed));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ir_s, ov_s;
      logic [DW-1:0] exp_d;

      //            fl  iv  d      or  ev  er  ed
      vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
      vecs[1]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01};
      vecs[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h02};
      vecs[3]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03};
      vecs[4]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04};
      vecs[5]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 8'h10};
      vecs[6]  = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h10};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10};
      vecs[8]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h10};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20};
      vecs[11] = '{1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 8'h30};
      vecs[12] = '{1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h30};
      vecs[13] = '{1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'h00};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
      vecs[15] = '{1'b0, 1'b1, 8'h60, 1'b0, 1'b1, 1'b1, 8'h60};
      vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
      vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
      vecs[18] = '{1'b0, 1'b1, 8'h70, 1'b0, 1'b1, 1'b1, 8'h70};
      vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h70};
      vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h70};

      // Reset held with live input traffic.
      rst_n = 1'b0;
      flush = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.data   = 8'hA5;
      out_bus.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      in_bus.valid = 1'b0;

      // Streaming, skid, drain and flush table.
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         flush         = vecs[i].fl;
         in_bus.valid  = vecs[i].iv;
         in_bus.data   = vecs[i].d;
         out_bus.ready = vecs[i].ordy;
         @(posedge clk);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ed);
      end
      @(negedge clk);
      flush = 1'b0;

      // Asynchronous reset while FULL discards both entries.
      in_bus.valid = 1'b1; in_bus.data = 8'hA1; out_bus.ready = 1'b0;
      @(negedge clk);
      in_bus.data = 8'hA2;
      @(negedge clk);
      in_bus.valid = 1'b0;
      check("full_before_rst.in_ready", 64'(in_bus.ready), 64'(1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      out_bus.ready = 1'b1;
      @(posedge clk);
      #1;
      check_outs("post_rst_idle", 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      in_bus.valid = 1'b1; in_bus.data = 8'h11;
      @(posedge clk);
      #1;
      check_outs("post_rst_first", 1'b1, 1'b1, 8'h11);
      @(negedge clk);
      in_bus.valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_drain.out_valid", 64'(out_bus.valid), 64'(1'b0));

      // Random backpressure against a scoreboard.
      ir_s = in_bus.ready;
      ov_s = out_bus.valid;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if (in_bus.ready !== ir_s) check("rand.in_ready_stable", 64'(in_bus.ready), 64'(ir_s));
         if (out_bus.valid !== ov_s) check("rand.out_valid_stable", 64'(out_bus.valid), 64'(ov_s));
         in_bus.valid  = ($urandom_range(0, 9) < 7);
         in_bus.data   = 8'($urandom);
         out_bus.ready = ($urandom_range(0, 9) < 6);
         if (in_bus.valid && in_bus.ready) sb_q.push_back(in_bus.data);
         if (out_bus.valid && out_bus.ready) begin
            if (sb_q.size() == 0) begin
               check("rand.sb_underflow", 64'(out_bus.data), 64'hDEAD_0000);
            end else begin
               exp_d = sb_q.pop_front();
               n_checks++;
               if (out_bus.data !== exp_d) begin
                  n_fail++;
                  $display("FAIL rand.sb_data cycle %0d: got %0h expected %0h", c, out_bus.data, exp_d);
               end
            end
         end
         @(posedge clk);
         #1;
         ir_s = in_bus.ready;
         ov_s = out_bus.valid;
      end
      $display("ok   rand: 10000 cycles, %0d beats outstanding before drain", sb_q.size());

      // Bounded drain.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_bus.valid  = 1'b0;
         out_bus.ready = 1'b1;
         if (out_bus.valid) begin
            if (sb_q.size() == 0) begin
               check("drain.sb_underflow", 64'(out_bus.data), 64'hDEAD_0000);
            end else begin
               exp_d = sb_q.pop_front();
               check("drain.sb_data", 64'(out_bus.data), 64'(exp_d));
            end
         end
         @(posedge clk);
      end
      #1;
      check("drain.sb_empty", 64'(sb_q.size()), 64'd0);
      check("drain.out_valid", 64'(out_bus.valid), 64'(1'b0));

`ifdef PIPE_STAGE_STALL_CNT_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_bus.valid = 1'b1; in_bus.data = 8'h55; out_bus.ready = 1'b0;
      @(posedge clk);
      #1;
      check("stall.start", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      in_bus.valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("stall.count5", 64'(stall_cnt), 64'd5);
      repeat (15) @(posedge clk);
      #1;
      check("stall.saturate", 64'(stall_cnt), 64'd15);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check("stall.after_flush", 64'(stall_cnt), 64'd15);
      @(negedge clk);
      flush = 1'b0;
      rst_n = 1'b0;
      #1;
      check("stall.reset_clear", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Elastic, parametrised pipeline register.
- Adds a valid/ready handshake, a two-entry skid buffer and a synchronous flush to the plain clear/hold stage register.
- Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and bus adapters.
- Sustains full throughput with a registered in_ready, so no combinational ready path crosses stages.

Parameters:
- DW, 64, payload width in bits (>=1).
- CLEAR_DATA, 1, 1: flush and reset zero both data registers; 0: data registers are left untouched on flush.
- CW, 32, stall counter width; used only when PIPE_STAGE_STALL_CNT_EN is defined.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous stage kill, highest priority.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  registered; stage can accept this cycle.
- in_data  input  DW  upstream payload.
- out_valid  output  1  registered; out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  payload, driven directly from the main register.
- stall_cnt  output  CW  present only with PIPE_STAGE_STALL_CNT_EN.

Behaviour:
- Reset: rst_n low asynchronously forces state EMPTY, out_valid=0, in_ready=1, main=0, skid=0 and stall_cnt=0. All inputs are ignored while rst_n is low.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Latency and throughput:
  - Accepted data appears on out_data with out_valid=1 the next cycle (latency 1).
  - Throughput is 1 beat per cycle.
  - Data is never duplicated, dropped (except by flush) or reordered.
- States (registered, 2 bits):
  - EMPTY: out_valid=0, in_ready=1.
    - in_valid: main<=in_data, go to BUSY.
  - BUSY: out_valid=1, in_ready=1.
    - in_valid & out_ready: main<=in_data, stay in BUSY.
    - in_valid & !out_ready: skid<=in_data, go to FULL.
    - !in_valid & out_ready: go to EMPTY.
    - Otherwise hold.
  - FULL: out_valid=1, in_ready=0.
    - out_ready: main<=skid, go to BUSY.
    - Otherwise hold; main and skid are stable.
- Outputs: in_ready and out_valid are decoded from the registered state only. No input-to-output combinational path exists.
- Flush:
  - Next state is EMPTY regardless of handshake.
  - An output transfer in the flush cycle still counts as consumed downstream.
  - Any input transfer in the flush cycle is discarded.
  - With CLEAR_DATA=1, main and skid are zeroed.
  - Flush while EMPTY has no effect other than CLEAR_DATA zeroing.
- out_data is stable while out_valid=1 and out_ready=0, whether in BUSY or FULL.
- Reset asserted mid-transfer discards all content. The first cycle after deassertion behaves as EMPTY.
- An illegal state encoding recovers to EMPTY on the next edge.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds the stall_cnt output and a CW-bit counter.
  - Increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones.
  - Cleared only by rst_n; flush does not clear it.
- Undefined: no stall_cnt port and no counter logic; CW is ignored.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=0xA5 -> out_valid=0, in_ready=1, out_data=0. After release, first in_valid=1 in_data=0x11 gives out_data=0x11 with out_valid=1 one cycle later.
- Streaming: out_ready=1, send 0x1,0x2,0x3,0x4 on consecutive cycles -> out_valid high 4 consecutive cycles starting cycle+1, data in order, in_ready constantly 1.
- Skid: BUSY holding 0x10, out_ready=0, send 0x20 -> in_ready=0 next cycle, out_data stays 0x10. Raise out_ready -> 0x10 then 0x20 delivered; in_ready returns to 1 after the first drain.
- Flush: FULL with 0x30/0x40, assert flush for 1 cycle with in_valid=1 in_data=0x50 -> next cycle out_valid=0, in_ready=1; 0x40 and 0x50 never appear; data regs=0 (CLEAR_DATA=1).
- Random backpressure: 10k cycles random in_valid/out_ready -> scoreboard shows out sequence == accepted in sequence; in_ready and out_valid never change except on clk edge or reset.
- Stall counter (macro on, CW=4): hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt saturates at 15; flush leaves it at 15; rst_n clears it to 0.
